// File: rtl/ret_addr_stack.sv
// Return-address stack for the fetch stage.
// Circular buffer of DEPTH 16-bit return addresses. A call pushes
// pc_plus1 and a ret pops the top entry. Pushing while full overwrites
// the oldest entry and sets the sticky ovf flag. Popping while empty
// leaves the state unchanged and sets the sticky unf flag.
//
// Strobe semantics:
// - call and ret are single-cycle decode strobes. There is no ready or
//   back-pressure path: every strobe not masked by stall is consumed at
//   the next rising edge.
// - call has priority over ret. A cycle with both asserted is a push only.
// - addr_ret is combinational from registered state, so it is valid in
//   the same cycle ret is presented.
module ret_addr_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             call,
    input  logic             ret,
    input  logic             stall,
    input  logic             clr_err,
    input  logic [15:0]      pc_plus1,
    output logic [15:0]      addr_ret,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   depth_cnt,
    output logic             ovf,
    output logic             unf
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic             is_full;
    logic             is_empty;
    logic             ovf_ev;
    logic             unf_ev;

    // Decode the effective operations and the error events for this cycle.
    always_comb begin
        push     = call & ~stall;
        pop      = ret & ~call & ~stall;
        is_full  = (count == DEPTH_CNT);
        is_empty = (count == '0);
        ovf_ev   = push & is_full;
        unf_ev   = pop & is_empty;
        top_idx  = sp - 1'b1;
    end

    // Entry storage. It is not reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= pc_plus1;
        end
    end

    // Stack pointer, occupancy count and sticky error flags.
    // sp wraps naturally in both directions. count saturates at 0 and DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (push) begin
                sp <= sp + 1'b1;
                if (!is_full) begin
                    count <= count + 1'b1;
                end
            end else if (pop && !is_empty) begin
                sp    <= sp - 1'b1;
                count <= count - 1'b1;
            end
            // A new event in the same cycle as clr_err wins.
            ovf <= (ovf & ~clr_err) | ovf_ev;
            unf <= (unf & ~clr_err) | unf_ev;
        end
    end

    // Present the top of stack, or zero when the stack is empty.
    always_comb begin
        addr_ret  = is_empty ? 16'h0000 : mem[top_idx];
        empty     = is_empty;
        full      = is_full;
        depth_cnt = count;
    end

endmodule

// File: tb/tb_ret_addr_stack.sv
// Testbench for ret_addr_stack.
// A queue-based reference model supplies every expected value. The
// stimulus is a run of directed steps followed by random traffic.
module tb_ret_addr_stack;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk;
  logic             rst_n;
  logic             call;
  logic             ret;
  logic             stall;
  logic             clr_err;
  logic [15:0]      pc_plus1;
  logic [15:0]      addr_ret;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   depth_cnt;
  logic             ovf;
  logic             unf;

  int checks   = 0;
  int failures = 0;

  // Reference model: the back of the queue is the top of the stack.
  logic [15:0] exp_q[$];
  logic        m_ovf;
  logic        m_unf;

  ret_addr_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .call      (call),
    .ret       (ret),
    .stall     (stall),
    .clr_err   (clr_err),
    .pc_plus1  (pc_plus1),
    .addr_ret  (addr_ret),
    .empty     (empty),
    .full      (full),
    .depth_cnt (depth_cnt),
    .ovf       (ovf),
    .unf       (unf)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_top();
    if (exp_q.size() == 0) return 16'h0000;
    return exp_q[exp_q.size() - 1];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Apply one clock edge to the reference model.
  task automatic model_edge(input logic c, input logic r, input logic s,
                            input logic e, input logic [15:0] pc);
    logic do_push;
    logic do_pop;
    logic ev_ovf;
    logic ev_unf;
    do_push = c && !s;
    do_pop  = r && !c && !s;
    ev_ovf  = 1'b0;
    ev_unf  = 1'b0;
    if (do_push) begin
      if (exp_q.size() == DEPTH) begin
        void'(exp_q.pop_front());
        ev_ovf = 1'b1;
      end
      exp_q.push_back(pc);
    end else if (do_pop) begin
      if (exp_q.size() == 0) ev_unf = 1'b1;
      else void'(exp_q.pop_back());
    end
    m_ovf = (e ? 1'b0 : m_ovf) | ev_ovf;
    m_unf = (e ? 1'b0 : m_unf) | ev_unf;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr_ret"}, 32'(addr_ret), 32'(model_top()));
    chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    chk({tag, ".depth_cnt"}, 32'(depth_cnt), 32'(exp_q.size()));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(unf), 32'(m_unf));
  endtask

  // Driver: called just after a falling edge. It checks the same-cycle
  // top, clocks one rising edge, then checks all outputs at the falling edge.
  task automatic step(input string tag, input logic c, input logic r, input logic s,
                      input logic e, input logic [15:0] pc);
    call     = c;
    ret      = r;
    stall    = s;
    clr_err  = e;
    pc_plus1 = pc;
    #1;
    chk({tag, ".pre_top"}, 32'(addr_ret), 32'(model_top()));
    @(posedge clk);
    model_edge(c, r, s, e, pc);
    @(negedge clk);
    call    = 1'b0;
    ret     = 1'b0;
    stall   = 1'b0;
    clr_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [3:0]  d_before;
    logic [15:0] rpc;
    logic        rc, rr, rs, re;

    call     = 1'b0;
    ret      = 1'b0;
    stall    = 1'b0;
    clr_err  = 1'b0;
    pc_plus1 = 16'h0000;
    rst_n    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // A pop on an empty stack shows 0 and sets unf.
    step("unf_empty", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("unf_set", 32'(unf), 32'd1);

    // LIFO order on three consecutive pushes.
    step("push10", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
    step("push20", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
    step("push30", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030);
    chk("lifo_top", 32'(addr_ret), 32'h0030);
    chk("lifo_depth", 32'(depth_cnt), 32'd3);
    for (int i = 0; i < 3; i++) step("pop3", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("lifo_empty", 32'(empty), 32'd1);

    // Nine pushes overflow: the oldest entry is lost.
    step("clr0", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 1; i <= 9; i++) step("ovf_push", 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h0100 + i));
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step("ovf_pop", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    end
    chk("ovf_drained", 32'(empty), 32'd1);
    step("ovf_unf", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("ovf_unf_flag", 32'(unf), 32'd1);

    // Simultaneous call and ret is a push.
    step("push1234", 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    d_before = depth_cnt;
    step("call_ret", 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    chk("call_ret_top", 32'(addr_ret), 32'hBEEF);
    chk("call_ret_depth", 32'(depth_cnt), 32'(d_before) + 32'd1);

    // Stall masks both push and pop; clr_err then clears the flags.
    d_before = depth_cnt;
    step("stall_call", 1'b1, 1'b0, 1'b1, 1'b0, 16'h7777);
    step("stall_ret", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("stall_top", 32'(addr_ret), 32'hBEEF);
    chk("stall_depth", 32'(depth_cnt), 32'(d_before));
    step("clr_err", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_unf", 32'(unf), 32'd0);

    // A clear in the same cycle as a new underflow: set wins.
    for (int i = 0; i < 2; i++) step("drain", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step("clr_vs_unf", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    chk("set_wins", 32'(unf), 32'd1);

    // Asynchronous reset between edges with five entries on the stack.
    for (int i = 0; i < 5; i++) step("fill5", 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'hA000 + i));
    chk("fill5_depth", 32'(depth_cnt), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    call     = 1'b1;
    pc_plus1 = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    call  = 1'b0;
    rst_n = 1'b1;
    check_all("rst_discard");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rc  = ($urandom_range(0, 99) < 45);
      rr  = ($urandom_range(0, 99) < 50);
      rs  = ($urandom_range(0, 99) < 20);
      re  = ($urandom_range(0, 99) < 5);
      rpc = 16'($urandom_range(0, 65535));
      step("rand", rc, rr, rs, re, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- Hardware return-address stack feeding the next-PC selector: supplies the 16-bit `addr_ret` consumed on a `ret`, and captures `pc_plus1` on every `call`.
- Sits in the fetch stage beside the PC register, driven by the same `call`/`ret` decode strobes that steer the next-PC mux.
- Circular buffer: overflow overwrites the oldest entry, underflow is flagged. Both error conditions are reported through sticky flags.

Parameters:
- DEPTH, 8, number of 16-bit entries; must be a power of two (2..64).
- PTR_W, 3, pointer width = log2(DEPTH); must be consistent with DEPTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- call  input  1  push request: `pc_plus1` is the return address to save.
- ret  input  1  pop request: the current `addr_ret` is being consumed this cycle.
- stall  input  1  pipeline hold; when 1 no push/pop takes effect.
- clr_err  input  1  synchronous clear of the sticky error flags.
- pc_plus1  input  16  address of the instruction after the call.
- addr_ret  output  16  top-of-stack entry; 16'h0000 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- depth_cnt  output  PTR_W+1  number of valid entries, 0..DEPTH.
- ovf  output  1  sticky: a push occurred while full.
- unf  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (`rst_n`=0, async): `sp`=0, `count`=0, `ovf`=0, `unf`=0. Outputs go immediately to `addr_ret`=0, `empty`=1, `full`=0, `depth_cnt`=0. Entry storage need not be reset.
- Effective operations:
  - `push` = `call` & ~`stall`.
  - `pop` = `ret` & ~`call` & ~`stall`.
  - `call` has priority over `ret`, matching the next-PC mux; a cycle with both asserted is a push only.
- `addr_ret` is combinational from registered state: `mem[(sp-1) mod DEPTH]` when `count`>0, else 0. It is valid in the same cycle `ret` is asserted, with zero added latency. A pop or push updates it from the next cycle on.
- Push (rising edge):
  - `mem[sp]` <= `pc_plus1`; `sp` <= `sp`+1 mod DEPTH.
  - `count` <= min(`count`+1, DEPTH).
  - If `count`==DEPTH before the edge: the oldest entry is overwritten (natural wrap), `count` stays DEPTH, and `ovf` <= 1.
- Pop (rising edge):
  - If `count`>0: `sp` <= `sp`-1 mod DEPTH; `count` <= `count`-1.
  - If `count`==0: `sp` and `count` are unchanged, `unf` <= 1, and `addr_ret` remains 0.
- Stall: `sp`, `count` and `mem` hold. `addr_ret` keeps presenting the same top. Sticky flags are not set.
- Sticky flags:
  - `clr_err` clears `ovf`/`unf` on the edge.
  - If a new error event occurs in the same cycle as `clr_err`, set wins (flag = 1).
  - Flags are otherwise held until reset.
- Pointer wrap: `sp` is PTR_W bits and wraps naturally in both directions. `count` is PTR_W+1 bits and saturates at 0 and DEPTH.
- Back-to-back: a push followed by a pop in the next cycle returns exactly the pushed value. Alternating push/pop on consecutive cycles needs no bubbles.
- Reset asserted mid-operation: state is cleared asynchronously. Any push or pop sampled at that edge is discarded.

Test Plan:
- Reset release, then `ret`=1 for one cycle -> `addr_ret`=0, `empty`=1; after the edge `unf`=1, `depth_cnt`=0.
- Push 16'h0010, 16'h0020, 16'h0030 on consecutive cycles -> `depth_cnt`=3, `addr_ret`=16'h0030. Three pops return 16'h0030, 16'h0020, 16'h0010 (each visible while `ret` is high), then `empty`=1.
- DEPTH=8: push 16'h0101..16'h0109 (9 pushes) -> `full`=1, `ovf`=1, `depth_cnt`=8. Eight pops yield 0109..0102; a 9th pop sets `unf`=1.
- `call`=1 & `ret`=1 with `pc_plus1`=16'hBEEF on a stack whose top is 16'h1234 -> after the edge `addr_ret`=16'hBEEF and `depth_cnt` increases by 1.
- `stall`=1 with `call`=1 (`pc_plus1`=16'h7777) and then `ret`=1 -> no change to `addr_ret`/`depth_cnt`, no flags set. `clr_err` with no new event clears `ovf`/`unf` to 0.
- Assert `rst_n`=0 between clock edges with `depth_cnt`=5 -> `addr_ret`=0, `empty`=1, `depth_cnt`=0 immediately, without waiting for a clock edge.
